clause_sweep_scheduler: RTL and testbench

- Sequences one full inference over the convolutional clause engine: for every class and every clause it drives the clause BRAM index, holds the engine active for exactly the patch-window sweep, and pulses the final-done strobe.
- Samples the OR-reduced clause output and clears the engine between clauses with a one-cycle image reset.
- Accumulates signed class votes (even clause +1, odd clause −1) and reports the argmax class.
- Sits between the top-level host/image loader and the conv clause array.

---
 rtl/clause_sched_pkg.sv | 40 ++++
 rtl/vote_argmax_acc.sv | 77 +++++++
 rtl/clause_sweep_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_clause_sweep_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/clause_sched_pkg.sv
// Shared types and arithmetic helpers for the clause sweep scheduler.
// The optional VOTE_CLAMP_EN build only affects vote_argmax_acc.
package clause_sched_pkg;

   localparam int VOTE_W = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLR    = 3'd1,
      LOAD   = 3'd2,
      RUN    = 3'd3,
      DRAIN  = 3'd4,
      SAMPLE = 3'd5,
      FINAL  = 3'd6
   } sched_state_e;

   // Engine cycles per clause: row bands of npe patch rows, one window column per cycle.
   function automatic logic [15:0] calc_run_len(input logic [15:0] img_w, input logic [15:0] img_h,
                                                input logic [2:0] p, input logic [2:0] s,
                                                input logic [15:0] npe);
      logic [15:0] py;
      logic [15:0] px;
      py = (img_h - {13'd0, p}) / {13'd0, s} + 16'd1;
      px = (img_w - {13'd0, p}) / {13'd0, s} + 16'd1;
      calc_run_len = ((py + npe - 16'd1) / npe) * px;
   endfunction

   function automatic logic signed [VOTE_W-1:0] sat_vote(input logic signed [VOTE_W-1:0] cur,
                                                         input logic dec,
                                                         input logic signed [VOTE_W-1:0] lim);
      if (dec) begin
         if (cur <= -lim) sat_vote = -lim;
         else             sat_vote = cur - 8'sd1;
      end else begin
         if (cur >= lim)  sat_vote = lim;
         else             sat_vote = cur + 8'sd1;
      end
   endfunction

endpackage

// File: rtl/vote_argmax_acc.sv
// Per-class signed vote accumulators with saturation and lowest-index-wins argmax.
// Defining VOTE_CLAMP_EN saturates each sum at +/-VOTE_T instead of +/-127.
module vote_argmax_acc
   import clause_sched_pkg::*;
#(
   parameter int CLASSN = 5,
   parameter int VOTE_T = 15
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clr,
   input  logic                        vote_en,
   input  logic                        vote_dec,
   input  logic [$clog2(CLASSN)-1:0]   class_sel,
   input  logic                        capture,
   output logic [CLASSN*VOTE_W-1:0]    class_sum_flat,
   output logic [$clog2(CLASSN)-1:0]   pred_class
);
   localparam int CLS_W = $clog2(CLASSN);
`ifdef VOTE_CLAMP_EN
   localparam bit CLAMP_ON = 1'b1;
`else
   localparam bit CLAMP_ON = 1'b0;
`endif
   localparam int LIM_I = CLAMP_ON ? VOTE_T : 32'sd127;
   localparam logic signed [VOTE_W-1:0] SAT_LIM = VOTE_W'(LIM_I);

   logic signed [VOTE_W-1:0] sum_r     [CLASSN];
   logic signed [VOTE_W-1:0] sum_nxt_s [CLASSN];
   logic signed [VOTE_W-1:0] best_val_s;
   logic [CLS_W-1:0]         best_idx_s;
   logic [CLS_W-1:0]         pred_class_r;

   // Next sums with the pending vote folded in, so the final argmax sees the last clause.
   always_comb begin
      for (int c = 0; c < CLASSN; c++) begin
         if (vote_en && (class_sel == CLS_W'(c))) sum_nxt_s[c] = sat_vote(sum_r[c], vote_dec, SAT_LIM);
         else                                      sum_nxt_s[c] = sum_r[c];
      end
   end

   // Strictly-greater scan keeps the lowest index on ties.
   always_comb begin
      best_idx_s = {CLS_W{1'b0}};
      best_val_s = sum_nxt_s[0];
      for (int c = 1; c < CLASSN; c++) begin
         if (sum_nxt_s[c] > best_val_s) begin
            best_idx_s = CLS_W'(c);
            best_val_s = sum_nxt_s[c];
         end else begin
            best_idx_s = best_idx_s;
            best_val_s = best_val_s;
         end
      end
   end

   // Sum registers and prediction capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CLASSN; c++) sum_r[c] <= {VOTE_W{1'b0}};
         pred_class_r <= {CLS_W{1'b0}};
      end else begin
         for (int c = 0; c < CLASSN; c++) begin
            if (clr) sum_r[c] <= {VOTE_W{1'b0}};
            else     sum_r[c] <= sum_nxt_s[c];
         end
         if (capture) pred_class_r <= best_idx_s;
         else         pred_class_r <= pred_class_r;
      end
   end

   for (genvar g = 0; g < CLASSN; g++) begin : g_flat
      assign class_sum_flat[g*VOTE_W +: VOTE_W] = sum_r[g];
   end
   assign pred_class = pred_class_r;

endmodule

// File: rtl/clause_sweep_scheduler.sv
// Sequences clear/load/run/drain/sample over every class and clause, then reports argmax.
// Vote saturation limit is selectable through VOTE_CLAMP_EN (see vote_argmax_acc).
module clause_sweep_scheduler
   import clause_sched_pkg::*;
#(
   parameter int IMG_WIDTH  = 32,
   parameter int IMG_HEIGHT = 32,
   parameter int CLAUSEN    = 10,
   parameter int CLASSN     = 5,
   parameter int NPE        = 8,
   parameter int BRAM_LAT   = 2,
   parameter int PIPE_LAT   = 3,
   parameter int VOTE_T     = 15
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic                           abort,
   input  logic [2:0]                     cfg_stride,
   input  logic [2:0]                     cfg_patch_size,
   input  logic [$clog2(CLAUSEN):0]       cfg_clauses,
   input  logic                           clause_op,
   output logic [$clog2(CLASSN)-1:0]      class_no,
   output logic [$clog2(CLAUSEN):0]       clause_no,
   output logic                           clause_act,
   output logic                           img_rst,
   output logic                           done_final,
   output logic                           busy,
   output logic                           cfg_err,
   output logic [CLASSN*VOTE_W-1:0]       class_sum_flat,
   output logic [$clog2(CLASSN)-1:0]      pred_class,
   output logic                           pred_valid
);
   localparam int CLS_W = $clog2(CLASSN);
   localparam int CLA_W = $clog2(CLAUSEN) + 1;

   sched_state_e     state_r, state_nxt_s;
   logic [15:0]      cnt_r, dur_s, run_len_r;
   logic [CLS_W-1:0] class_r;
   logic [CLA_W-1:0] clause_r, clauses_r;
   logic cfg_ok_s, accept_s, last_clause_s, last_class_s;
   logic clause_act_s, img_rst_s, done_final_s, busy_s, cfg_err_s, pred_valid_s;
   logic clause_act_r, img_rst_r, done_final_r, busy_r, cfg_err_r, pred_valid_r;

   // Start-time configuration validation.
   always_comb begin
      cfg_ok_s = 1'b0;
      case (cfg_patch_size)
         3'd3, 3'd5, 3'd7: cfg_ok_s = (cfg_stride != 3'd0) && (cfg_clauses != {CLA_W{1'b0}}) &&
                                      (cfg_clauses <= CLA_W'(CLAUSEN));
         default:          cfg_ok_s = 1'b0;
      endcase
   end

   assign accept_s      = (state_r == IDLE) && start && !abort && cfg_ok_s;
   assign last_clause_s = ({1'b0, clause_r} + {{CLA_W{1'b0}}, 1'b1}) >= {1'b0, clauses_r};
   assign last_class_s  = (class_r == CLS_W'(CLASSN - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_nxt_s;
   end

   // Next-state logic; abort overrides everything.
   always_comb begin
      state_nxt_s = state_r;
      if (abort) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    if (accept_s) state_nxt_s = CLR;    else state_nxt_s = IDLE;
            CLR:     state_nxt_s = LOAD;
            LOAD:    if (cnt_r == 16'd0) state_nxt_s = RUN;    else state_nxt_s = LOAD;
            RUN:     if (cnt_r == 16'd0) state_nxt_s = DRAIN;  else state_nxt_s = RUN;
            DRAIN:   if (cnt_r == 16'd0) state_nxt_s = SAMPLE; else state_nxt_s = DRAIN;
            SAMPLE:  if (last_clause_s && last_class_s) state_nxt_s = FINAL; else state_nxt_s = CLR;
            FINAL:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // Outputs decoded from the next state so the registered copies line up with state_r.
   always_comb begin
      clause_act_s = 1'b0;
      img_rst_s    = 1'b0;
      done_final_s = 1'b0;
      busy_s       = 1'b0;
      pred_valid_s = 1'b0;
      cfg_err_s    = (state_r == IDLE) && start && !abort && !cfg_ok_s;
      case (state_nxt_s)
         CLR:     begin img_rst_s = 1'b1; busy_s = 1'b1; end
         LOAD:    busy_s = 1'b1;
         RUN:     begin clause_act_s = 1'b1; busy_s = 1'b1; end
         DRAIN:   busy_s = 1'b1;
         SAMPLE:  begin done_final_s = 1'b1; busy_s = 1'b1; end
         FINAL:   pred_valid_s = 1'b1;
         default: busy_s = 1'b0;
      endcase
   end

   // Dwell length loaded on entry to each timed state.
   always_comb begin
      case (state_nxt_s)
         LOAD:    dur_s = 16'(BRAM_LAT - 1);
         RUN:     dur_s = run_len_r - 16'd1;
         DRAIN:   dur_s = 16'(PIPE_LAT - 1);
         default: dur_s = 16'd0;
      endcase
   end

   // Dwell counter, latched configuration and class/clause indices.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r     <= 16'd0;
         run_len_r <= 16'd0;
         clauses_r <= {CLA_W{1'b0}};
         class_r   <= {CLS_W{1'b0}};
         clause_r  <= {CLA_W{1'b0}};
      end else begin
         if (state_nxt_s != state_r) cnt_r <= dur_s;
         else if (cnt_r != 16'd0)    cnt_r <= cnt_r - 16'd1;
         else                        cnt_r <= cnt_r;
         if (accept_s) begin
            run_len_r <= calc_run_len(16'(IMG_WIDTH), 16'(IMG_HEIGHT), cfg_patch_size, cfg_stride, 16'(NPE));
            clauses_r <= cfg_clauses;
            class_r   <= {CLS_W{1'b0}};
            clause_r  <= {CLA_W{1'b0}};
         end else if ((state_r == SAMPLE) && (state_nxt_s == CLR)) begin
            if (!last_clause_s) begin
               clause_r <= clause_r + CLA_W'(1'b1);
            end else begin
               clause_r <= {CLA_W{1'b0}};
               class_r  <= class_r + CLS_W'(1'b1);
            end
         end else begin
            clause_r <= clause_r;
         end
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clause_act_r <= 1'b0;
         img_rst_r    <= 1'b0;
         done_final_r <= 1'b0;
         busy_r       <= 1'b0;
         cfg_err_r    <= 1'b0;
         pred_valid_r <= 1'b0;
      end else begin
         clause_act_r <= clause_act_s;
         img_rst_r    <= img_rst_s;
         done_final_r <= done_final_s;
         busy_r       <= busy_s;
         cfg_err_r    <= cfg_err_s;
         pred_valid_r <= pred_valid_s;
      end
   end

   vote_argmax_acc #(.CLASSN(CLASSN), .VOTE_T(VOTE_T)) u_vote (
      .clk            (clk),
      .rst_n          (rst_n),
      .clr            (accept_s),
      .vote_en        ((state_r == SAMPLE) && !abort && clause_op),
      .vote_dec       (clause_r[0]),
      .class_sel      (class_r),
      .capture        (state_nxt_s == FINAL),
      .class_sum_flat (class_sum_flat),
      .pred_class     (pred_class)
   );

   assign class_no   = class_r;
   assign clause_no  = clause_r;
   assign clause_act = clause_act_r;
   assign img_rst    = img_rst_r;
   assign done_final = done_final_r;
   assign busy       = busy_r;
   assign cfg_err    = cfg_err_r;
   assign pred_valid = pred_valid_r;

endmodule

// File: tb/tb_clause_sweep_scheduler.sv
// Randomized self-checking bench for clause_sweep_scheduler against a behavioural vote model.
// With VOTE_CLAMP_EN the bench widens CLAUSEN so a single class can collect 20 hits.
module tb_clause_sweep_scheduler;
`ifdef VOTE_CLAMP_EN
   localparam int CN  = 40;
   localparam int LIM = 15;
`else
   localparam int CN  = 10;
   localparam int LIM = 127;
`endif
   localparam int KN = 5, IW = 32, IH = 32, NPE = 8;
   localparam int CLW = $clog2(CN) + 1, KW = $clog2(KN);

   logic clk = 1'b0;
   logic rst_n, start, abort, clause_op;
   logic [2:0] cfg_stride, cfg_patch_size;
   logic [CLW-1:0] cfg_clauses;
   logic [KW-1:0] class_no, pred_class;
   logic [CLW-1:0] clause_no;
   logic clause_act, img_rst, done_final, busy, cfg_err, pred_valid;
   logic [KN*8-1:0] class_sum_flat;

   int n_checks = 0;
   int n_errors = 0;
   int exp_sum [KN];

   clause_sweep_scheduler #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .CLAUSEN(CN), .CLASSN(KN), .NPE(NPE),
                            .BRAM_LAT(2), .PIPE_LAT(3), .VOTE_T(15)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_stride(cfg_stride),
      .cfg_patch_size(cfg_patch_size), .cfg_clauses(cfg_clauses), .clause_op(clause_op),
      .class_no(class_no), .clause_no(clause_no), .clause_act(clause_act), .img_rst(img_rst),
      .done_final(done_final), .busy(busy), .cfg_err(cfg_err), .class_sum_flat(class_sum_flat),
      .pred_class(pred_class), .pred_valid(pred_valid));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int got_sum(input int c);
      return int'($signed(class_sum_flat[c*8 +: 8]));
   endfunction

   function automatic int exp_run_len(input int p, input int s);
      int py, px;
      py = (IH - p) / s + 1;
      px = (IW - p) / s + 1;
      return ((py + NPE - 1) / NPE) * px;
   endfunction

   function automatic int exp_argmax();
      int best = 0;
      for (int c = 1; c < KN; c++) if (exp_sum[c] > exp_sum[best]) best = c;
      return best;
   endfunction

   task automatic check_sums(input string tag);
      for (int c = 0; c < KN; c++) check_eq(tag, got_sum(c), exp_sum[c]);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_act"}, clause_act, 0);
      check_eq({tag, "_imgrst"}, img_rst, 0);
      check_eq({tag, "_done"}, done_final, 0);
      check_eq({tag, "_pv"}, pred_valid, 0);
      check_eq({tag, "_cfgerr"}, cfg_err, 0);
      check_eq({tag, "_class"}, class_no, 0);
      check_eq({tag, "_clause"}, clause_no, 0);
      check_eq({tag, "_pred"}, pred_class, 0);
      check_eq({tag, "_sums"}, (class_sum_flat == '0) ? 1 : 0, 1);
   endtask

   task automatic bad_cfg(input int p, input int s, input int ncl);
      int act = 0;
      cfg_patch_size = 3'(p); cfg_stride = 3'(s); cfg_clauses = CLW'(ncl);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("cfgerr_pulse", cfg_err, 1);
      check_eq("cfgerr_busy", busy, 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (clause_act || img_rst || busy || cfg_err) act++;
      end
      check_eq("cfgerr_quiet", act, 0);
   endtask

   // mode: 0 random, 1 all zero, 2 class3/clause0 only, 3 even clauses of class 1
   task automatic run_inf(input int p, input int s, input int ncl, input int mode,
                          input int abort_cls, input bit poke);
      int k_cls = 0, k_cla = 0, act_len = 0, n_done = 0, n_rst = 0, n_err = 0, cyc = 0;
      int rl, quiet;
      bit fin = 0, aborted = 0;
      rl = exp_run_len(p, s);
      for (int c = 0; c < KN; c++) exp_sum[c] = 0;
      cfg_patch_size = 3'(p); cfg_stride = 3'(s); cfg_clauses = CLW'(ncl);
      start = 1'b1;
      tick();
      start = 1'b0;
      cfg_patch_size = 3'($urandom_range(0, 7));
      cfg_stride = 3'($urandom_range(0, 7));
      cfg_clauses = CLW'($urandom_range(0, CN));
      check_eq("start_busy", busy, 1);
      while (!fin && !aborted && cyc < 20000) begin
         if (clause_act) act_len++;
         else if (act_len != 0) begin
            check_eq("run_len", act_len, rl);
            act_len = 0;
         end
         if (cfg_err) n_err++;
         if (img_rst) begin
            n_rst++;
            check_eq("clr_class", class_no, k_cls);
            check_eq("clr_clause", clause_no, k_cla);
         end
         if (clause_act && act_len == 1) check_eq("run_clause", clause_no, k_cla);
         if (mode == 0 || !done_final) clause_op = 1'($urandom_range(0, 1));
         else if (mode == 1) clause_op = 1'b0;
         else if (mode == 2) clause_op = (k_cls == 3 && k_cla == 0);
         else clause_op = (k_cls == 1 && (k_cla % 2) == 0);
         if (done_final) begin
            n_done++;
            check_eq("smp_class", class_no, k_cls);
            check_eq("smp_clause", clause_no, k_cla);
            if (clause_op) begin
               exp_sum[k_cls] += ((k_cla % 2) == 0) ? 1 : -1;
               if (exp_sum[k_cls] > LIM) exp_sum[k_cls] = LIM;
               if (exp_sum[k_cls] < -LIM) exp_sum[k_cls] = -LIM;
            end
            k_cla++;
            if (k_cla == ncl) begin k_cla = 0; k_cls++; end
         end
         if (pred_valid) begin
            check_eq("pred_class", pred_class, exp_argmax());
            check_eq("final_busy", busy, 0);
            check_sums("final_sum");
            fin = 1;
         end
         start = (poke && cyc == 40);
         if (abort_cls >= 0 && clause_act && k_cls == abort_cls && act_len == 5) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check_eq("abort_busy", busy, 0);
            check_eq("abort_act", clause_act, 0);
            aborted = 1;
         end else begin
            tick();
            cyc++;
         end
      end
      start = 1'b0;
      if (aborted) begin
         quiet = 0;
         for (int i = 0; i < 30; i++) begin
            if (pred_valid || busy || clause_act || img_rst) quiet++;
            tick();
         end
         check_eq("abort_quiet", quiet, 0);
         check_sums("abort_sum");
      end else begin
         check_eq("timeout", fin, 1);
         check_eq("n_done", n_done, KN * ncl);
         check_eq("n_imgrst", n_rst, KN * ncl);
         check_eq("busy_cfgerr", n_err, 0);
         tick();
         check_eq("post_pv", pred_valid, 0);
         check_eq("post_busy", busy, 0);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; clause_op = 1'b0;
      cfg_patch_size = 3'd3; cfg_stride = 3'd1; cfg_clauses = CLW'(2);
      repeat (2) tick();
      check_idle_outputs("reset");
      @(negedge clk) rst_n = 1'b1;
      tick();

      bad_cfg(4, 1, 2);
      bad_cfg(3, 0, 2);
      bad_cfg(5, 1, 0);
      bad_cfg(7, 2, CN + 1);

      // abort beats start in IDLE
      cfg_patch_size = 3'd3; cfg_stride = 3'd1; cfg_clauses = CLW'(2);
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check_eq("abort_start_busy", busy, 0);
      check_eq("abort_start_imgrst", img_rst, 0);
      check_eq("abort_start_cfgerr", cfg_err, 0);
      tick();

      run_inf(3, 1, 2, 0, -1, 1'b1);
      run_inf(7, 2, 3, 2, -1, 1'b0);
      check_eq("held_pred", pred_class, 3);

      // reset asserted during LOAD clears everything asynchronously
      cfg_patch_size = 3'd3; cfg_stride = 3'd1; cfg_clauses = CLW'(2);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check_eq("load_busy", busy, 1);
      check_eq("load_act", clause_act, 0);
      #2 rst_n = 1'b0;
      #1 check_idle_outputs("midrst");
      @(negedge clk) rst_n = 1'b1;
      tick();

      run_inf(5, 3, 2, 1, -1, 1'b0);
      run_inf(3, 1, 3, 0, 2, 1'b0);
      run_inf(7, 2, CN, 3, -1, 1'b0);
      check_eq("even_hits", got_sum(1), (CN / 2 > LIM) ? LIM : CN / 2);
      for (int r = 0; r < 3; r++)
         run_inf(3 + 2 * $urandom_range(0, 2), $urandom_range(1, 7), $urandom_range(1, 4), 0, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
